// File: rtl/mem_arbiter.sv
// Serializes CPU fetch and data requests onto one single-port memory with a req/ack handshake.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data wins over fetch.
module mem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDRSIZE-1:0] i_addr,
  output logic [WIDTH-1:0]    i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRSIZE-1:0] d_addr,
  input  logic [WIDTH-1:0]    d_wdata,
  output logic [WIDTH-1:0]    d_rdata,
  output logic                d_ack,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDRSIZE-1:0] m_addr,
  output logic [WIDTH-1:0]    m_wdata,
  input  logic [WIDTH-1:0]    m_rdata,
  output logic                busy,
  output logic                last_grant
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [1:0] LatM1 = 2'(MEM_LAT - 1);

  state_e              r_state, w_state_next;
  logic [1:0]          r_cnt, w_cnt_next;
  logic                r_m_en, w_m_en_next;
  logic                r_m_we, w_m_we_next;
  logic [ADDRSIZE-1:0] r_m_addr, w_m_addr_next;
  logic [WIDTH-1:0]    r_m_wdata, w_m_wdata_next;
  logic                r_we, w_we_next;
  logic                r_last_grant, w_last_grant_next;
  logic                r_i_ack, w_i_ack_next;
  logic                r_d_ack, w_d_ack_next;
  logic [WIDTH-1:0]    r_i_rdata, w_i_rdata_next;
  logic [WIDTH-1:0]    r_d_rdata, w_d_rdata_next;
  logic                r_busy, w_busy_next;
  logic                w_any_req;
  logic                w_grant_d;

  assign w_any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, serve the port that was not served last.
  assign w_grant_d = d_req & (~i_req | ~r_last_grant);
`else
  assign w_grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_next = StIssue;
      StIssue: begin
        w_cnt_next   = LatM1;
        w_state_next = (MEM_LAT <= 1) ? StAck : StWait;
      end
      StWait: begin
        w_cnt_next = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) w_state_next = StAck;
      end
      StAck:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Next values of the registered outputs; the strobe is raised while entering ISSUE.
  always_comb begin
    w_m_en_next       = 1'b0;
    w_m_we_next       = 1'b0;
    w_m_addr_next     = r_m_addr;
    w_m_wdata_next    = r_m_wdata;
    w_we_next         = r_we;
    w_last_grant_next = r_last_grant;
    w_i_ack_next      = 1'b0;
    w_d_ack_next      = 1'b0;
    w_i_rdata_next    = r_i_rdata;
    w_d_rdata_next    = r_d_rdata;
    w_busy_next       = (w_state_next != StIdle);
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_m_en_next       = 1'b1;
          w_m_we_next       = w_grant_d & d_we;
          w_we_next         = w_grant_d & d_we;
          w_m_addr_next     = w_grant_d ? d_addr : i_addr;
          w_m_wdata_next    = w_grant_d ? d_wdata : '0;
          w_last_grant_next = w_grant_d;
        end
      end
      StAck: begin
        if (r_last_grant) begin
          w_d_ack_next = 1'b1;
          if (!r_we) w_d_rdata_next = m_rdata;
        end else begin
          w_i_ack_next   = 1'b1;
          w_i_rdata_next = m_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_en       <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_we         <= 1'b0;
      r_last_grant <= 1'b0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_m_en       <= w_m_en_next;
      r_m_we       <= w_m_we_next;
      r_m_addr     <= w_m_addr_next;
      r_m_wdata    <= w_m_wdata_next;
      r_we         <= w_we_next;
      r_last_grant <= w_last_grant_next;
      r_i_ack      <= w_i_ack_next;
      r_d_ack      <= w_d_ack_next;
      r_i_rdata    <= w_i_rdata_next;
      r_d_rdata    <= w_d_rdata_next;
      r_busy       <= w_busy_next;
    end
  end

  assign m_en       = r_m_en;
  assign m_we       = r_m_we;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign i_ack      = r_i_ack;
  assign d_ack      = r_d_ack;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model on a MEM_LAT=1 instance,
// plus directed timing and reset checks on a MEM_LAT=3 instance.
module tb_mem_arbiter;

  localparam int unsigned LAT = 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] TieOrder = 4'b0101;  // bit k = grant k: D,I,D,I
`else
  localparam logic [3:0] TieOrder = 4'b1111;  // D,D,D,D
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [11:0] rand_addr();
    return 12'($urandom_range(0, 15));
  endfunction

  // ---------------- MEM_LAT=1 instance ----------------
  logic        rst, i_req, i_ack, d_req, d_we, d_ack, m_en, m_we, busy, last_grant;
  logic [11:0] i_addr, d_addr, m_addr;
  logic [31:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

  mem_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .last_grant(last_grant)
  );

  logic [31:0] dmem1 [4096];
  initial begin
    for (int i = 0; i < 4096; i++) dmem1[i] = init_word(i);
    dmem1[12'h010] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (m_en) begin
        if (m_we) dmem1[m_addr] = m_wdata;
        else m_rdata <= dmem1[m_addr];
      end
    end
  end

  // ---------------- MEM_LAT=3 instance ----------------
  logic        rst3, i_req3, i_ack3, d_req3, d_we3, d_ack3, m_en3, m_we3, busy3, last_grant3;
  logic [11:0] i_addr3, d_addr3, m_addr3;
  logic [31:0] i_rdata3, d_rdata3, d_wdata3, m_wdata3, m_rdata3;
  logic [31:0] p3a, p3b, p3c;
  assign m_rdata3 = p3c;

  mem_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ack(i_ack3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_ack(d_ack3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .busy(busy3), .last_grant(last_grant3)
  );

  logic [31:0] dmem3 [4096];
  initial begin
    for (int i = 0; i < 4096; i++) dmem3[i] = init_word(i);
    forever begin
      @(posedge clk);
      p3c <= p3b;
      p3b <= p3a;
      if (m_en3 && !m_we3) p3a <= dmem3[m_addr3];
      if (m_en3 && m_we3) dmem3[m_addr3] = m_wdata3;
    end
  end

  // ---------------- Reference model (transaction level) ----------------
  logic [31:0] refmem [4096];
  int unsigned cyc = 0, free_at = 0, t_e0 = 0;
  bit          mv = 1'b0, have = 1'b0, t_port = 1'b0, t_we = 1'b0, win = 1'b0, e_lg = 1'b0;
  logic [31:0] t_rdata = '0;
  bit          e_m_en = 1'b0, e_m_we = 1'b0, e_i_ack = 1'b0, e_d_ack = 1'b0, e_busy = 1'b0;
  logic [11:0] e_m_addr = '0;
  logic [31:0] e_m_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;

  initial begin
    for (int i = 0; i < 4096; i++) refmem[i] = init_word(i);
    refmem[12'h010] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      cyc++;
      mv = 1'b1;
      if (rst) begin
        have = 1'b0; free_at = cyc + 1;
        e_m_en = 0; e_m_we = 0; e_m_addr = '0; e_m_wdata = '0; e_i_ack = 0; e_d_ack = 0;
        e_i_rdata = '0; e_d_rdata = '0; e_busy = 0; e_lg = 0;
      end else begin
        e_m_en = 0; e_m_we = 0; e_i_ack = 0; e_d_ack = 0;
        if (have && cyc == t_e0 + LAT + 1) begin
          if (t_port) begin
            e_d_ack = 1;
            if (!t_we) e_d_rdata = t_rdata;
          end else begin
            e_i_ack = 1;
            e_i_rdata = t_rdata;
          end
          have = 1'b0;
        end
        if (cyc >= free_at && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
          win = (i_req && d_req) ? !e_lg : d_req;
`else
          win = d_req;
`endif
          have = 1'b1; t_e0 = cyc; free_at = cyc + LAT + 2;
          t_port = win; t_we = win && d_we;
          e_m_addr = win ? d_addr : i_addr;
          e_m_en = 1; e_m_we = t_we; e_lg = win;
          if (t_we) begin
            e_m_wdata = d_wdata;
            refmem[d_addr] = d_wdata;
          end else begin
            t_rdata = refmem[e_m_addr];
          end
        end
        e_busy = have && (cyc <= t_e0 + LAT);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        chk("m_en", m_en, e_m_en);
        chk("m_we", m_we, e_m_we);
        chk("m_addr", m_addr, e_m_addr);
        if (e_m_we) chk("m_wdata", m_wdata, e_m_wdata);
        chk("i_ack", i_ack, e_i_ack);
        chk("d_ack", d_ack, e_d_ack);
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("busy", busy, e_busy);
        chk("last_grant", last_grant, e_lg);
      end
    end
  end

  // ---------------- Stimulus ----------------
  int   wr_pulses, n, cnt_a, cnt_b;
  bit   i_seen, got;
  logic [3:0] order;

  task automatic step_watch();
    @(negedge clk);
    if (m_en && m_we) wr_pulses++;
    if (i_ack) i_seen = 1'b1;
  endtask

  initial begin
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    rst3 = 1; i_req3 = 0; i_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_en", m_en, 0);       chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_ack", i_ack, 0);     chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);       chk("rst_last_grant", last_grant, 0);
    rst = 0; rst3 = 0;

    // Fetch from 0x010
    i_addr = 12'h010; i_req = 1;
    @(negedge clk);
    chk("fetch_m_en", m_en, 1); chk("fetch_m_addr", m_addr, 12'h010); chk("fetch_busy", busy, 1);
    @(negedge clk);
    chk("fetch_m_en_drop", m_en, 0); chk("fetch_early_ack", i_ack, 0);
    @(negedge clk);
    chk("fetch_ack", i_ack, 1); chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 0;
    @(negedge clk);
    chk("fetch_ack_pulse", i_ack, 0); chk("fetch_busy_done", busy, 0);

    // Data write 7 to 0x005, then read it back
    wr_pulses = 0; i_seen = 0; got = 0;
    d_addr = 12'h005; d_wdata = 32'h7; d_we = 1; d_req = 1;
    for (int k = 0; k < 12 && !got; k++) begin
      step_watch();
      if (d_ack) begin got = 1; d_req = 0; end
    end
    chk("wr_ack_seen", got, 1);
    repeat (2) step_watch();
    chk("wr_m_we_pulses", wr_pulses, 1);
    got = 0; d_we = 0; d_wdata = 32'hFFFF_FFFF; d_req = 1;
    for (int k = 0; k < 12 && !got; k++) begin
      step_watch();
      if (d_ack) begin
        got = 1; d_req = 0;
        chk("rd_back_data", d_rdata, 32'h7);
      end
    end
    chk("rd_ack_seen", got, 1);
    repeat (2) step_watch();
    chk("no_i_ack", i_seen, 0);

    // Both requests held for four accesses, starting from reset
    rst = 1;
    @(negedge clk);
    rst = 0; i_addr = 12'h020; d_addr = 12'h021; d_we = 0; i_req = 1; d_req = 1;
    n = 0; order = '0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (m_en) begin order[n] = last_grant; n++; end
    end
    repeat (2) @(negedge clk);
    i_req = 0; d_req = 0;
    chk("tie_count", n, 4);
    chk("tie_order", order, TieOrder);
    repeat (2) @(negedge clk);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = rand_addr();
      end else if (i_req && $urandom_range(0, 3) == 0) begin
        i_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 3) == 0) begin
        d_addr = rand_addr(); d_wdata = $urandom;
      end
      if (i_req && $urandom_range(0, 19) == 0) i_req = 0;
      if (d_req && $urandom_range(0, 19) == 0) d_req = 0;
    end
    @(negedge clk);
    rst = 0; i_req = 0; d_req = 0;
    repeat (6) @(negedge clk);

    // MEM_LAT=3: fetch 0x0FF, ack at E0+4, next request accepted at E0+5
    i_addr3 = 12'h0FF; i_req3 = 1;
    @(negedge clk);
    chk("l3_m_en", m_en3, 1); chk("l3_busy", busy3, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_en3) cnt_a++;
      if (i_ack3) cnt_b++;
    end
    chk("l3_no_reissue", cnt_a, 0); chk("l3_no_early_ack", cnt_b, 0);
    @(negedge clk);
    chk("l3_ack", i_ack3, 1); chk("l3_rdata", i_rdata3, init_word(12'h0FF));
    chk("l3_busy_ack", busy3, 0);
    i_addr3 = 12'h0FE;
    @(negedge clk);
    chk("l3_next_accept", m_en3, 1); chk("l3_next_addr", m_addr3, 12'h0FE);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (i_ack3) begin
        got = 1; i_req3 = 0;
        chk("l3_second_rdata", i_rdata3, init_word(12'h0FE));
      end
    end
    chk("l3_second_ack", got, 1);

    // Reset during WAIT of a data read on the MEM_LAT=3 instance
    @(negedge clk);
    d_addr3 = 12'h0AB; d_we3 = 0; d_req3 = 1;
    @(negedge clk);
    chk("l3r_m_en", m_en3, 1);
    @(negedge clk);
    rst3 = 1;
    @(negedge clk);
    rst3 = 0; d_req3 = 0;
    chk("l3r_m_en_low", m_en3, 0); chk("l3r_busy", busy3, 0);
    chk("l3r_last_grant", last_grant3, 0); chk("l3r_i_rdata_clr", i_rdata3, 0);
    cnt_a = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack3) cnt_a++;
    end
    chk("l3r_no_ack", cnt_a, 0);
    d_req3 = 1;
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (d_ack3) begin
        got = 1; d_req3 = 0;
        chk("l3r_after_rdata", d_rdata3, init_word(12'h0AB));
        chk("l3r_after_grant", last_grant3, 1);
      end
    end
    chk("l3r_after_ack", got, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port arbiter that shares a single-port 4096x32 memory between the CPU instruction-fetch port and the CPU data port. Sits between `instruction_set_model` and a unified memory, so a single memory array holds both program and data. Each requester gets a req/ack handshake. Requests are serialized through a small FSM with a configurable memory read latency.

## Interface
- WIDTH, 32, data path width
- ADDRSIZE, 12, address width (memory depth 2^ADDRSIZE)
- MEM_LAT, 1, memory read latency in cycles from m_en to valid m_rdata; legal range 1..3

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  ADDRSIZE  fetch address
- i_rdata  out  WIDTH  fetched word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDRSIZE  data address
- d_wdata  in  WIDTH  write data
- d_rdata  out  WIDTH  read word, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, only with m_en
- m_addr  out  ADDRSIZE  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data
- busy  out  1  high in any state other than IDLE
- last_grant  out  1  0 = last served instruction port, 1 = last served data port

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req is high, arbitrate, latch winner's addr/we/wdata, record the winner in last_grant, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive m_en=1, m_addr, m_we (=d_we for data, 0 for fetch), m_wdata. Load the latency counter with MEM_LAT-1. Go to WAIT, or to ACK if MEM_LAT=1.
- WAIT: decrement the counter; at 0 go to ACK.
- ACK: capture m_rdata into the winner's rdata register and pulse the winner's ack; always go to IDLE. No arbitration in ACK, so the acked requester's still-high req is never re-served.
- Writes use the same sequence; d_rdata on a write ack is undefined-but-stable (holds the previous value).
- Arbitration without the macro: fixed priority, data port wins over fetch.
- The losing request stays pending; it is served in the next IDLE if still asserted.
- Inputs are sampled only in IDLE; changes to addr/wdata after the grant are ignored.
- A req dropped after grant does not abort the access; the ack still pulses.
- i_rdata/d_rdata hold their last captured value between acks.

## Timing
- Reset values: m_en=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, busy=0, last_grant=0, FSM=IDLE, counter=0.
- All outputs are registered.
- Let E0 be the edge at which req is sampled in IDLE:
  - m_en is high for the cycle after E0.
  - ack is high for the cycle after edge E0+MEM_LAT+1.
  - the FSM is back in IDLE after E0+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles, i.e. 3 cycles at MEM_LAT=1.
- A request asserted in the ACK cycle is sampled at the next IDLE edge, with no extra bubble.
- rst high at any edge, including mid-access:
  - the FSM returns to IDLE;
  - m_en/m_we are forced low next cycle;
  - the pending ack is never issued;
  - rdata registers are cleared to 0.
- Simultaneous rst and req: rst wins.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both reqs are high in IDLE, grant the port opposite to last_grant. Because last_grant resets to 0, the first tie after reset goes to data. A single requester is always granted.
- Not defined: fixed data-over-fetch priority; last_grant is still updated for observation.

## Test plan
- Fetch only, MEM_LAT=1, mem[0x010]=0xDEADBEEF, i_req with i_addr=0x010 -> m_en one cycle after sample edge, i_ack one cycle at E0+2 with i_rdata=0xDEADBEEF, busy low again after E0+3.
- Data write then read, d_addr=0x005, d_wdata=0x00000007 -> m_we=1 with m_en exactly once. A subsequent read of 0x005 returns d_rdata=7 with d_ack pulse; i_ack stays 0 throughout.
- Both reqs held high for 4 accesses, MEM_LAT=1:
  - without the macro: grant order D,D,D,D while d_req stays high;
  - with ARB_ROUND_ROBIN_EN: order D,I,D,I, with last_grant toggling 1,0,1,0.
- MEM_LAT=3, fetch 0x0FF -> ack at E0+4; no second m_en during WAIT; the next request accepted at E0+5.
- rst pulsed in the WAIT state of a data read -> no d_ack ever appears, m_en=0, busy=0, last_grant=0 after the reset edge. A new d_req after reset completes normally.
